// File: rtl/stream_mux_pkg.sv
// Shared types, mode encodings and the round-robin pick helper for the stream_mux_rr family.
// Supports up to 32 channels; callers zero-extend their request and pointer vectors.
package stream_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;
    localparam int   MAX_CH   = 32;

    typedef enum logic {
        LK_IDLE,
        LK_LOCKED
    } lock_state_t;

    // Scans ptr+1, ptr+2, ... (mod nCh) and returns the first valid channel as a one-hot vector.
    function automatic logic [MAX_CH-1:0] rr_pick(
        input logic [MAX_CH-1:0] valid,
        input logic [4:0]        ptr,
        input int                nCh
    );
        logic [MAX_CH-1:0] gnt;
        logic              found;
        int                idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = (int'(ptr) + i) % nCh;
            if ((i <= nCh) && !found && valid[idx[4:0]]) begin
                gnt[idx[4:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus encoded index, starting after ptr.
// Holds no state; the pointer lives in the instantiating module.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx
);

    logic [MAX_CH-1:0] reqWide;
    logic [MAX_CH-1:0] gntWide;

    always_comb begin
        reqWide = MAX_CH'(req);
        gntWide = rr_pick(reqWide, 5'(ptr), N_CH);
        gnt     = gntWide[N_CH-1:0];
        gnt_idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (gntWide[i]) begin
                gnt_idx = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with external-select or round-robin arbitration and a registered output.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until the end of its packet.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH   = 8,
    parameter  int DATA_W = 32,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_chan
);

    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q,  outData_d;
    logic              outLast_q,  outLast_d;
    logic [SEL_W-1:0]  outChan_q,  outChan_d;
    logic [SEL_W-1:0]  rrPtr_q,    rrPtr_d;

    logic              canLoad;
    logic              xfer;
    logic [N_CH-1:0]   selGnt;
    logic [N_CH-1:0]   rrGnt;
    logic [N_CH-1:0]   grant;
    logic [SEL_W-1:0]  rrIdx;
    logic [SEL_W-1:0]  grantIdx;
    logic [DATA_W-1:0] muxData;
    logic              muxLast;

`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_state_t       lockState_q, lockState_d;
    logic [SEL_W-1:0]  lockCh_q,    lockCh_d;
`endif

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rrPtr_q),
        .gnt     (rrGnt),
        .gnt_idx (rrIdx)
    );

    // An out-of-range sel matches no channel, so it can never produce a grant.
    always_comb begin
        selGnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                selGnt[i] = in_valid[i];
            end
        end
    end

    always_comb begin
        grant    = '0;
        grantIdx = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lockState_q == LK_LOCKED) begin
            grant[lockCh_q] = in_valid[lockCh_q];
            grantIdx        = lockCh_q;
        end else
`endif
        if (mode == MODE_RR) begin
            grant    = rrGnt;
            grantIdx = rrIdx;
        end else begin
            grant    = selGnt;
            grantIdx = sel;
        end
    end

    always_comb begin
        canLoad  = !outValid_q || out_ready;
        in_ready = (canLoad && !rst) ? grant : '0;
        xfer     = |(in_valid & in_ready);
        muxData  = '0;
        muxLast  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grantIdx == SEL_W'(i)) begin
                muxData = in_data[i*DATA_W +: DATA_W];
                muxLast = in_last[i];
            end
        end
    end

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        outChan_d  = outChan_q;
        rrPtr_d    = rrPtr_q;
        if (canLoad) begin
            outValid_d = xfer;
            if (xfer) begin
                outData_d = muxData;
                outLast_d = muxLast;
                outChan_d = grantIdx;
                rrPtr_d   = grantIdx;
            end
        end
    end

    // Pointer starts at the last channel so channel 0 wins the first round-robin pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outLast_q  <= 1'b0;
            outChan_q  <= '0;
            rrPtr_q    <= SEL_W'(N_CH - 1);
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outLast_q  <= outLast_d;
            outChan_q  <= outChan_d;
            rrPtr_q    <= rrPtr_d;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lockState_q <= LK_IDLE;
            lockCh_q    <= '0;
        end else begin
            lockState_q <= lockState_d;
            lockCh_q    <= lockCh_d;
        end
    end

    always_comb begin
        lockState_d = lockState_q;
        lockCh_d    = lockCh_q;
        case (lockState_q)
            LK_IDLE: begin
                if (xfer && !muxLast) begin
                    lockState_d = LK_LOCKED;
                    lockCh_d    = grantIdx;
                end
            end
            LK_LOCKED: begin
                if (xfer && muxLast) begin
                    lockState_d = LK_IDLE;
                end
            end
            default: lockState_d = LK_IDLE;
        endcase
    end
`endif

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_last  = outLast_q;
    assign out_chan  = outChan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: an 8-channel instance tracked by a reference model and a 6-channel instance for range checks.
// Expected sequences follow STREAM_MUX_PKT_LOCK_EN when it is defined.
module tb_stream_mux_rr;

    localparam int N = 8;
    localparam int W = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [2:0]  chan;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         mode;
    logic [2:0]   sel;
    logic [7:0]   inValid;
    logic [7:0]   inLast;
    logic [7:0]   inReady;
    logic [N*W-1:0] inData;
    logic         outReady;
    logic         outValid;
    logic [31:0]  outData;
    logic         outLast;
    logic [2:0]   outChan;

    logic [5:0]   inReady6;
    logic         outValid6;
    logic [31:0]  outData6;
    logic         outLast6;
    logic [2:0]   outChan6;

    int           checks;
    int           errors;
    beat_t        sbQ[$];
    logic [2:0]   obsChan[$];

    logic         mOutValid;
    int           mRrPtr;
    bit           mLocked;
    int           mLockCh;
    logic [7:0]   tag;
    int           ch2Beats;
    bit           chk6;
    bit           chk6Valid;
    logic [5:0]   exp6Ready;

    stream_mux_rr #(.N_CH(8), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .in_last   (inLast),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_last  (outLast),
        .out_chan  (outChan)
    );

    stream_mux_rr #(.N_CH(6), .DATA_W(32)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (inValid[5:0]),
        .in_ready  (inReady6),
        .in_data   (inData[6*W-1:0]),
        .in_last   (inLast[5:0]),
        .out_valid (outValid6),
        .out_ready (outReady),
        .out_data  (outData6),
        .out_last  (outLast6),
        .out_chan  (outChan6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    function automatic int modelGrant();
        int idx;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (mLocked) return inValid[mLockCh] ? mLockCh : -1;
`endif
        if (mode == 1'b0) return inValid[sel] ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            idx = (mRrPtr + k) % N;
            if (inValid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic modelXfer(input int g, input logic last);
        mRrPtr = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (!mLocked && !last) begin
            mLocked = 1'b1;
            mLockCh = g;
        end else if (mLocked && last) begin
            mLocked = 1'b0;
        end
`endif
        if (g == 2) ch2Beats++;
    endtask

    // One cycle: drive at the falling edge, check combinational and registered outputs, then advance the model.
    task automatic applyStimulus(input logic [7:0] valid, input logic [7:0] last, input logic md,
                                 input logic [2:0] s, input logic ordy);
        int         g;
        logic       canLoad;
        logic       consumed;
        logic [2:0] obs;
        beat_t      b;
        mode     = md;
        sel      = s;
        inValid  = valid;
        inLast   = last;
        outReady = ordy;
        for (int i = 0; i < N; i++) inData[i*W +: W] = {16'hA5A5, tag, 8'(i)};
        #1;
        checkOutput("outValid", 64'(outValid), 64'(mOutValid));
        if (mOutValid && sbQ.size() > 0) begin
            checkOutput("outData", 64'(outData), 64'(sbQ[0].data));
            checkOutput("outLast", 64'(outLast), 64'(sbQ[0].last));
            checkOutput("outChan", 64'(outChan), 64'(sbQ[0].chan));
        end
        canLoad = !mOutValid || ordy;
        g = modelGrant();
        checkOutput("inReady", 64'(inReady), (canLoad && g >= 0) ? (64'd1 << g) : 64'd0);
        if (chk6) begin
            checkOutput("six.inReady", 64'(inReady6), 64'(exp6Ready));
            if (chk6Valid) checkOutput("six.outValid", 64'(outValid6), 64'd0);
        end
        consumed = mOutValid && ordy;
        obs      = outChan;
        @(posedge clk);
        if (consumed && sbQ.size() > 0) begin
            void'(sbQ.pop_front());
            obsChan.push_back(obs);
        end
        if (canLoad) begin
            mOutValid = (g >= 0);
            if (g >= 0) begin
                b.data = inData[g*W +: W];
                b.last = last[g];
                b.chan = 3'(g);
                sbQ.push_back(b);
                modelXfer(g, last[g]);
            end
        end
        tag++;
        @(negedge clk);
    endtask

    task automatic applyReset(input int n, input logic [7:0] valid);
        rst      = 1'b1;
        inValid  = valid;
        outReady = 1'b1;
        for (int c = 0; c < n; c++) begin
            #1;
            checkOutput("rstInReady", 64'(inReady), 64'd0);
            checkOutput("rstInReady6", 64'(inReady6), 64'd0);
            @(posedge clk);
            @(negedge clk);
            checkOutput("rstOutValid", 64'(outValid), 64'd0);
            checkOutput("rstOutData", 64'(outData), 64'd0);
            checkOutput("rstOutValid6", 64'(outValid6), 64'd0);
        end
        rst = 1'b0;
        sbQ.delete();
        mOutValid = 1'b0;
        mRrPtr    = N - 1;
        mLocked   = 1'b0;
        mLockCh   = 0;
    endtask

    initial begin
        logic [2:0] expPkt[6];
        logic [7:0] t5Tag;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        inValid   = '0;
        inLast    = '0;
        inData    = '0;
        outReady  = 1'b1;
        tag       = 8'd0;
        ch2Beats  = 0;
        chk6      = 1'b0;
        chk6Valid = 1'b0;
        exp6Ready = '0;
        mOutValid = 1'b0;
        mRrPtr    = N - 1;
        mLocked   = 1'b0;
        mLockCh   = 0;
        @(negedge clk);

        $display("[TB] reset with all channels valid");
        applyReset(2, 8'hFF);

        $display("[TB] external select of channel 3");
        applyStimulus(8'h08, 8'hFF, 1'b0, 3'd3, 1'b1);
        checkOutput("selData", 64'(outData), 64'h0000_0000_A5A5_0003);
        checkOutput("selChan", 64'(outChan), 64'd3);
        applyStimulus(8'h08, 8'hFF, 1'b0, 3'd4, 1'b1);
        applyStimulus(8'h00, 8'hFF, 1'b0, 3'd0, 1'b1);

        $display("[TB] round robin over all channels");
        applyReset(1, 8'hFF);
        obsChan.delete();
        repeat (10) applyStimulus(8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1);
        checkOutput("rrSeqLen", 64'(obsChan.size()), 64'd9);
        for (int i = 0; i < 9 && i < obsChan.size(); i++) begin
            checkOutput("rrSeq", 64'(obsChan[i]), 64'(i % 8));
        end

        $display("[TB] backpressure");
        repeat (5) applyStimulus(8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0);
        repeat (3) applyStimulus(8'hFF, 8'hFF, 1'b1, 3'd0, 1'b1);

        $display("[TB] out-of-range select on the 6-channel instance");
        chk6      = 1'b1;
        exp6Ready = 6'b000000;
        applyStimulus(8'hFF, 8'hFF, 1'b0, 3'd7, 1'b1);
        chk6Valid = 1'b1;
        repeat (2) applyStimulus(8'hFF, 8'hFF, 1'b0, 3'd7, 1'b1);
        chk6Valid = 1'b0;
        exp6Ready = 6'b100000;
        t5Tag     = tag;
        applyStimulus(8'hFF, 8'hFF, 1'b0, 3'd5, 1'b0);
        chk6 = 1'b0;
        checkOutput("six.outValidHi", 64'(outValid6), 64'd1);
        checkOutput("six.outChan", 64'(outChan6), 64'd5);
        checkOutput("six.outData", 64'(outData6), 64'({16'hA5A5, t5Tag, 8'd5}));
        checkOutput("six.outLast", 64'(outLast6), 64'd1);

        $display("[TB] reset while a beat is pending");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 3'd0, 1'b0);
        applyReset(1, 8'hFF);

        $display("[TB] packet on channel 2 against channels 0 and 5");
        obsChan.delete();
        ch2Beats = 0;
        applyStimulus(8'h02, 8'hFF, 1'b1, 3'd0, 1'b1);
        applyStimulus(8'h25, (ch2Beats == 2) ? 8'hFF : 8'hFB, 1'b1, 3'd0, 1'b1);
        applyStimulus(8'h21, (ch2Beats == 2) ? 8'hFF : 8'hFB, 1'b1, 3'd0, 1'b1);
        repeat (4) applyStimulus(8'h25, (ch2Beats == 2) ? 8'hFF : 8'hFB, 1'b1, 3'd0, 1'b1);
        applyStimulus(8'h00, 8'hFF, 1'b1, 3'd0, 1'b1);
`ifdef STREAM_MUX_PKT_LOCK_EN
        expPkt = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd5, 3'd0};
`else
        expPkt = '{3'd1, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5};
`endif
        checkOutput("pktSeqLen", 64'(obsChan.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < obsChan.size(); i++) begin
            checkOutput("pktSeq", 64'(obsChan[i]), 64'(expPkt[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
